vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between VGA scan-out and two game-logic writers.
- Scan-out reads are scheduled from the display counter's hCount/vCount.
- Writers get every memory cycle the display does not need, arbitrated round-robin.
- Sits between the display counter, the game-logic blocks and the framebuffer RAM (160x120 cells, each cell shown as 4x4 screen pixels).

Parameters:
- ADDR_W, 15, framebuffer address width
- DATA_W, 8, framebuffer word / pixel colour width
- H_START, 144, first visible hCount
- V_START, 35, first visible vCount
- FB_W, 160, framebuffer cells per row
- FB_H, 120, framebuffer rows

Ports:
- clk  in  1  pixel clock (25 MHz); only clock
- rst_n  in  1  synchronous active-low reset
- hCount  in  10  horizontal position from display counter (0..799)
- vCount  in  10  vertical position from display counter (0..524)
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
- pix_data  out  DATA_W  colour for the current screen pixel
- pix_valid  out  1  pix_data belongs to visible area of a synced frame
- wr0_valid / wr1_valid  in  1  writer N request
- wr0_addr / wr1_addr  in  ADDR_W  writer N cell address
- wr0_data / wr1_data  in  DATA_W  writer N data
- wr0_ready / wr1_ready  out  1  writer N granted this cycle
- frame_start  out  1  one-cycle pulse at start of each frame
- wr_drop  out  1  sticky flag: out-of-range write accepted and discarded

Behaviour:
- All state updates on posedge clk. rst_n=0 sampled on an edge forces:
  - state=WAIT_SYNC, pix_data=0, pix_valid=0, frame_start=0, wr_drop=0, rr_ptr=0.
  - Combinational outputs are forced too: mem_we=0, wr0_ready=0, wr1_ready=0, mem_addr=0.
- FSM:
  - WAIT_SYNC -> SCAN when hCount==0 && vCount==0.
  - SCAN persists until reset. No display reads occur in WAIT_SYNC; writers are served in both states.
- frame_start is registered: it is 1 for exactly the cycle after the one where hCount==0 && vCount==0, in any state.
- Display slot (combinational):
  - Conditions: state==SCAN, vCount in [V_START, V_START+479], h' = hCount-(H_START-2) in [0,639], h'[1:0]==0.
  - In a slot: mem_addr = ((vCount-V_START)>>2)*FB_W + (h'>>2), mem_we=0, both readies 0.
  - Multiply uses shift-add (x*160 = x<<7 + x<<5), with no truncation below ADDR_W.
- Read pipeline:
  - Slot at cycle t; mem_rdata valid at t+1; pix_data <= mem_rdata on the edge ending t+1.
  - So the cell for hCount=H_START+4k is on pix_data from that hCount and held 4 clocks.
- pix_valid is registered: 1 on the cycle after one where state==SCAN, hCount in [H_START-1, H_START+638] and vCount in the visible range. This aligns it with pix_data. pix_data keeps its last value outside the visible area.
- Writer grant on a non-slot cycle (not in reset):
  - Only one valid: that writer gets ready=1.
  - Both valid: grant wr[rr_ptr]. On a completed transfer, rr_ptr <= index of the loser.
  - Neither valid: rr_ptr unchanged.
- Write transfer = valid & ready in the same cycle, driving mem_addr=wrN_addr and mem_wdata=wrN_data.
  - mem_we=1 only if wrN_addr < FB_W*FB_H (19200).
  - An out-of-range write still completes the handshake, mem_we=0, and sets wr_drop (cleared only by reset).
- Readies depend only on state, hCount, vCount, the valids and rr_ptr, never on addr or data.
- A writer holding valid must keep addr and data stable until ready. Waiting is bounded: at most 1 slot per 4 cycles, so a grant comes within 2 cycles if its rr turn.
- Idle cycles (no slot, no valid): mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-frame: returns to WAIT_SYNC and scan-out stops until the next hCount=0, vCount=0. Writes accepted before reset are not replayed.

Test Plan:
- Reset, then run the counter from (0,0) -> frame_start=1 on the cycle after (0,0); first slot at vCount=35, hCount=142 with mem_addr=0; pix_data=RAM[0], pix_valid=1 at hCount=144.
- Display cell addressing -> slot at vCount=39, hCount=146 issues mem_addr=161; slot at vCount=514, hCount=778 issues mem_addr=19199.
- wr0 and wr1 held valid during the visible line -> no grant on slot cycles (h'%4==0); grants alternate 0,1,0,1 on the other three cycles of each 4.
- wr1 valid alone with addr=5, data=0xAB during vblank -> wr1_ready=1 the same cycle, mem_we=1, mem_addr=5, mem_wdata=0xAB; a later display read of cell 5 shows 0xAB.
- wr0 write to addr=19200 -> handshake completes, mem_we=0, wr_drop=1 until next reset.
- Assert rst_n=0 at vCount=200 -> pix_valid=0 and no display reads until the next (0,0); writers still served after reset is released.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// and two game-logic writers. Display reads take every fourth pixel clock of
// the visible area; writers get all remaining cycles, arbitrated round-robin.
`timescale 1ns/1ps
module vga_fb_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr0_valid,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ready,
  input  logic              wr1_valid,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ready,
  output logic              frame_start,
  output logic              wr_drop
);

  typedef enum logic {WAIT_SYNC, SCAN} state_e;

  localparam int FB_CELLS = FB_W * FB_H;

  state_e            state_q, state_d;
  logic              frame_start_q;
  logic              pix_valid_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              rd_pend_q;     // a display read was issued last cycle
  logic              rr_ptr_q, rr_ptr_d;
  logic              wr_drop_q, wr_drop_d;

  // Screen-position decode. Reads are issued two clocks ahead of the pixel
  // they feed: one clock of RAM latency plus one for the pix_data register.
  logic              at_origin;
  logic              v_vis;
  logic              h_slot_range;
  logic              pix_window;
  logic              slot;
  logic [9:0]        h_rel;
  logic [9:0]        row_full;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] col_a;
  logic [ADDR_W-1:0] disp_addr;
  logic              grant0, grant1;
  logic              wr0_in_range, wr1_in_range;

  assign at_origin    = (hCount == 10'd0) && (vCount == 10'd0);
  assign v_vis        = (vCount >= 10'(V_START)) && (vCount <= 10'(V_START + 479));
  assign h_slot_range = (hCount >= 10'(H_START - 2)) && (hCount <= 10'(H_START + 637));
  assign pix_window   = (hCount >= 10'(H_START - 1)) && (hCount <= 10'(H_START + 638));
  assign h_rel        = hCount - 10'(H_START - 2);
  assign row_full     = (vCount - 10'(V_START)) >> 2;
  assign row_a        = ADDR_W'(row_full);
  assign col_a        = ADDR_W'(h_rel >> 2);
  // row*160 as shift-add; computed at full ADDR_W so the last row (119) fits.
  assign disp_addr    = (row_a << 7) + (row_a << 5) + col_a;
  assign slot         = (state_q == SCAN) && v_vis && h_slot_range && (h_rel[1:0] == 2'b00);

  // Arbitration looks only at valids and the pointer, never at addr/data.
  assign grant0       = wr0_valid && (!wr1_valid || !rr_ptr_q);
  assign grant1       = wr1_valid && (!wr0_valid ||  rr_ptr_q);
  assign wr0_in_range = wr0_addr < ADDR_W'(FB_CELLS);
  assign wr1_in_range = wr1_addr < ADDR_W'(FB_CELLS);

  // Next-state and memory-port mux: display slot first, then the granted writer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wr_drop_d = wr_drop_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr0_ready = 1'b0;
    wr1_ready = 1'b0;

    if (state_q == WAIT_SYNC && at_origin) state_d = SCAN;

    if (rst_n && !slot) begin
      if (grant0) begin
        wr0_ready = 1'b1;
        mem_addr  = wr0_addr;
        mem_wdata = wr0_data;
        mem_we    = wr0_in_range;
        if (!wr0_in_range) wr_drop_d = 1'b1;
      end else if (grant1) begin
        wr1_ready = 1'b1;
        mem_addr  = wr1_addr;
        mem_wdata = wr1_data;
        mem_we    = wr1_in_range;
        if (!wr1_in_range) wr_drop_d = 1'b1;
      end
      // Contention only: the pointer moves to whichever writer lost.
      if (wr0_valid && wr1_valid) rr_ptr_d = grant0;
    end else if (rst_n) begin
      mem_addr = disp_addr;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q       <= WAIT_SYNC;
      frame_start_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      rd_pend_q     <= 1'b0;
      rr_ptr_q      <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_start_q <= at_origin;
      pix_valid_q   <= (state_q == SCAN) && v_vis && pix_window;
      rd_pend_q     <= slot;
      rr_ptr_q      <= rr_ptr_d;
      wr_drop_q     <= wr_drop_d;
      if (rd_pend_q) pix_data_q <= mem_rdata;
    end
  end

  assign frame_start = frame_start_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign wr_drop     = wr_drop_q;

endmodule
